// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared frame-buffer geometry, pixel type and scan-state enum.
// Revision    : 1.0
// ============================================================================
package fb_pkg;

    localparam int H_ACTIVE     = 320;
    localparam int V_ACTIVE     = 240;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W       = 17;
    localparam int DATA_W       = 16;

    typedef logic [DATA_W-1:0] rgb565_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } scan_state_e;

    // One returned pixel plus its stream markers, as held in the skid FIFO.
    typedef struct packed {
        rgb565_t data;
        logic    sof;
        logic    eol;
        logic    last;
    } scan_beat_t;

endpackage
`default_nettype wire

// File: rtl/scanout_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : scanout_skid_fifo
// Description : Two-entry FIFO absorbing the frame buffer's read latency.
// Revision    : 1.0
// ============================================================================
module scanout_skid_fifo
    import fb_pkg::*;
#(
    parameter int WIDTH = DATA_W + 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = pop && (r_count != 2'd0);
    assign w_push_ok = push && ((r_count != 2'd2) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/frame_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : frame_scanout_reader
// Description : Raster read master for the dual frame buffer with
//               frame-boundary front/back buffer swapping.
// Revision    : 1.0
// ============================================================================
module frame_scanout_reader
    import fb_pkg::ADDR_W, fb_pkg::DATA_W, fb_pkg::scan_state_e, fb_pkg::scan_beat_t;
    import fb_pkg::S_IDLE, fb_pkg::S_SCAN, fb_pkg::S_DRAIN;
#(
    parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
    parameter int V_ACTIVE = fb_pkg::V_ACTIVE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              swap_req,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data_a,
    input  logic [DATA_W-1:0] read_data_b,
    output logic              front_sel,
    output logic              back_sel,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              frame_done,
    output logic              swap_ack
);

    localparam int X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BEAT_W = DATA_W + 3;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [X_W-1:0]    c_last_x    = X_W'(H_ACTIVE - 1);

    scan_state_e       r_state;
    scan_state_e       w_state_next;

    logic [ADDR_W-1:0] r_addr;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_scan_sel;
    logic              r_front_sel;
    logic              r_swap_pending;
    logic              r_inflight;
    logic              r_inflight_sof;
    logic              r_inflight_eol;
    logic              r_inflight_last;
    logic              r_frame_done;
    logic              r_swap_ack;

    logic              w_issue;
    logic              w_pop;
    logic              w_room;
    logic              w_last_accept;
    logic              w_swap_due;
    logic              w_at_last;
    logic [1:0]        w_fifo_count;
    logic [2:0]        w_occupancy;
    logic [BEAT_W-1:0] w_push_bits;
    logic [BEAT_W-1:0] w_head_bits;
    scan_beat_t        w_push_beat;
    scan_beat_t        w_head;

    // ------------------------------------------------------------------
    // Stream side
    // ------------------------------------------------------------------
    assign w_head        = scan_beat_t'(w_head_bits);
    assign m_valid       = (w_fifo_count != 2'd0);
    assign m_data        = m_valid ? w_head.data : '0;
    assign m_sof         = m_valid && w_head.sof;
    assign m_eol         = m_valid && w_head.eol;
    assign w_pop         = m_valid && m_ready;
    assign w_last_accept = w_pop && w_head.last && (r_state == S_DRAIN);
    assign w_swap_due    = r_swap_pending || swap_req;

    // Reads already issued but not yet accepted may never exceed the FIFO depth.
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room      = (w_occupancy < 3'd2);
    assign w_at_last   = (r_addr == c_last_addr);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_issue && w_at_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_accept) begin
                    w_state_next = enable ? S_SCAN : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Entering SCAN (from IDLE or at a frame boundary)
    // issues address 0 on the transition edge itself.
    // ------------------------------------------------------------------
    always_comb begin
        w_issue = 1'b0;
        unique case (r_state)
            S_IDLE:  w_issue = enable;
            S_SCAN:  w_issue = w_room;
            S_DRAIN: w_issue = w_last_accept && enable;
            default: w_issue = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation, return tagging and buffer selection
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr          <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_scan_sel      <= 1'b0;
            r_front_sel     <= 1'b0;
            r_swap_pending  <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_sof  <= 1'b0;
            r_inflight_eol  <= 1'b0;
            r_inflight_last <= 1'b0;
            r_frame_done    <= 1'b0;
            r_swap_ack      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_sof  <= (r_addr == '0);
                r_inflight_eol  <= (r_x == c_last_x);
                r_inflight_last <= w_at_last;
                if (w_at_last) begin
                    r_addr <= '0;
                    r_x    <= '0;
                    r_y    <= '0;
                end else begin
                    r_addr <= r_addr + 1'b1;
                    if (r_x == c_last_x) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
            end

            if ((r_state == S_IDLE) && enable) begin
                r_scan_sel <= r_front_sel;
            end else if (w_last_accept) begin
                r_scan_sel <= r_front_sel ^ w_swap_due;
            end

            r_frame_done   <= w_last_accept;
            r_swap_ack     <= w_last_accept && w_swap_due;
            r_swap_pending <= w_last_accept ? 1'b0 : w_swap_due;
            if (w_last_accept && w_swap_due) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // Return path
    // ------------------------------------------------------------------
    always_comb begin
        w_push_beat      = '0;
        w_push_beat.data = r_scan_sel ? read_data_b : read_data_a;
        w_push_beat.sof  = r_inflight_sof;
        w_push_beat.eol  = r_inflight_eol;
        w_push_beat.last = r_inflight_last;
    end

    assign w_push_bits = w_push_beat;

    scanout_skid_fifo #(
        .WIDTH     (BEAT_W)
    ) u_skid_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (r_inflight),
        .push_data (w_push_bits),
        .pop       (w_pop),
        .pop_data  (w_head_bits),
        .count     (w_fifo_count)
    );

    assign read_addr  = r_addr;
    assign front_sel  = r_front_sel;
    assign back_sel   = ~r_front_sel;
    assign frame_done = r_frame_done;
    assign swap_ack   = r_swap_ack;

endmodule
`default_nettype wire
